// File: rtl/aes_text_out_reader.sv
// Unloads the AES core's 128-bit text_out on its done strobe and streams it out
// as DATA_W-bit valid/ready beats, MS word first, counting dropped results.
module aes_text_out_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OVR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [127:0]      text_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [OVR_W-1:0]  ovr_cnt,
  input  logic              ovr_clr
);

  localparam int unsigned NBEATS = 128 / DATA_W;
  localparam int unsigned BeatW  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [127:0]       shift_q, shift_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic               last_q, last_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;
  logic               hs, drop;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    last_d  = last_q;
    drop    = 1'b0;
    hs      = (state_q == StSend) && m_ready;

    unique case (state_q)
      StIdle: begin
        if (done) begin
          state_d = StSend;
          shift_d = text_out;
          beat_d  = '0;
          last_d  = (NBEATS == 1);
        end
      end
      StSend: begin
        if (hs && last_q) begin
          if (done) begin
            // Back-to-back: reload without a bubble, not an overrun.
            shift_d = text_out;
            beat_d  = '0;
            last_d  = (NBEATS == 1);
          end else begin
            state_d = StIdle;
            shift_d = shift_q << DATA_W;
            beat_d  = '0;
            last_d  = 1'b0;
          end
        end else begin
          if (hs) begin
            shift_d = shift_q << DATA_W;
            beat_d  = beat_q + 1'b1;
            last_d  = (int'(beat_q) + 2 == int'(NBEATS));
          end
          drop = done;
        end
      end
    endcase

    // Clear applies before a same-cycle increment.
    ovr_d = ovr_clr ? '0 : ovr_q;
    if (drop && (ovr_d != {OVR_W{1'b1}})) begin
      ovr_d = ovr_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      beat_q  <= '0;
      last_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_valid = (state_q == StSend);
  assign busy    = (state_q == StSend);
  assign m_data  = shift_q[127 -: DATA_W];
  assign m_last  = last_q;
  assign ovr_cnt = ovr_q;

endmodule
